// File: rtl/dff_bank_pkg.sv
// rtl/dff_bank_pkg.sv - mode encodings and pin-field indices for the DFF shift bank tile
package dff_bank_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_RSVD  = 2'b10;
    localparam logic [1:0] MODE_ROT   = 2'b11;

    localparam int UI_MODE_LO  = 4;
    localparam int UI_MODE_HI  = 5;
    localparam int UI_IN_VALID = 6;
    localparam int UI_SCLR     = 7;

    localparam int UO_FULL     = 4;
    localparam int UIO_TAP_LO  = 4;
    localparam int OCC_MAX     = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/dff_bank_stage.sv
// rtl/dff_bank_stage.sv - one data word plus valid bit with load-enable and sync clear
module dff_bank_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid
);

    // Clear outranks load so a single decode in the top can assert both safely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data  <= '0;
            q_valid <= 1'b0;
        end else if (clr) begin
            q_data  <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q_data  <= d_data;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/tt_um_dff_shift_bank.sv
// rtl/tt_um_dff_shift_bank.sv - DEPTH-stage shift/rotate register bank TinyTapeout tile
module tt_um_dff_shift_bank
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_SEL = 5'(DEPTH);

    logic [WIDTH-1:0] din;
    logic [1:0]       mode;
    logic             in_valid;
    logic             sclr;

    assign din      = ui_in[WIDTH-1:0];
    assign mode     = ui_in[UI_MODE_HI:UI_MODE_LO];
    assign in_valid = ui_in[UI_IN_VALID];
    assign sclr     = ui_in[UI_SCLR];

    logic [WIDTH-1:0] q_data [DEPTH];
    logic [WIDTH-1:0] d_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] d_valid;
    logic             stage_load;
    logic             stage_clr;

    // ena gates everything, so a clear requested while disabled is dropped.
    always_comb begin
        stage_clr  = ena & sclr;
        stage_load = 1'b0;
        if (ena && !sclr) begin
            case (mode)
                MODE_SHIFT, MODE_ROT: stage_load = 1'b1;
                MODE_HOLD, MODE_RSVD: stage_load = 1'b0;
                default:              stage_load = 1'b0;
            endcase
        end
    end

    always_comb begin
        if (mode == MODE_ROT) begin
            d_data[0]  = q_data[DEPTH-1];
            d_valid[0] = q_valid[DEPTH-1];
        end else begin
            d_data[0]  = din;
            d_valid[0] = in_valid;
        end
        for (int i = 1; i < DEPTH; i++) begin
            d_data[i]  = q_data[i-1];
            d_valid[i] = q_valid[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        dff_bank_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (stage_load),
            .clr    (stage_clr),
            .d_data (d_data[g]),
            .d_valid(d_valid[g]),
            .q_data (q_data[g]),
            .q_valid(q_valid[g])
        );
    end

    logic [3:0] pop;
    logic [2:0] occ;
    logic       full;
    logic [3:0] tail_ext;

    always_comb begin
        pop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pop = pop + 4'(q_valid[i]);
        end
        occ = (pop > 4'(OCC_MAX)) ? 3'(OCC_MAX) : pop[2:0];
    end

    assign full = &q_valid;

    always_comb begin
        tail_ext             = '0;
        tail_ext[WIDTH-1:0]  = q_data[DEPTH-1];
    end

    assign uo_out = {occ, full, tail_ext};

    logic [3:0]       tap_sel;
    logic [IDX_W-1:0] tap_idx;
    logic [3:0]       tap_ext;

    assign tap_sel = uio_in[3:0];
    assign tap_idx = uio_in[IDX_W-1:0];

    // Out-of-range selects read as zero rather than aliasing onto a real stage.
    always_comb begin
        tap_ext = '0;
        if ({1'b0, tap_sel} < DEPTH_SEL) begin
            tap_ext[WIDTH-1:0] = q_data[tap_idx];
        end
    end

    assign uio_out = {tap_ext, 4'b0000};
    assign uio_oe  = UIO_OE_VAL;

    logic unused_pins;
    assign unused_pins = &{1'b0, uio_in[7:UIO_TAP_LO], ui_in[3:0], 1'b0};

endmodule

// File: tb/tb_tt_um_dff_shift_bank.sv
// tb/tb_tt_um_dff_shift_bank.sv - scoreboard bench for the DFF shift bank tile
module tb_tt_um_dff_shift_bank;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_dff_shift_bank #(
        .WIDTH(4),
        .DEPTH(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] m_data [4];
    logic       m_valid [4];
    logic [7:0] exp_q [$];

    function automatic logic [7:0] model_uo();
        int cnt;
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += m_valid[i];
        return {3'(cnt), (cnt == 4) ? 1'b1 : 1'b0, m_data[3]};
    endfunction

    function automatic logic [7:0] model_tap(input logic [3:0] sel);
        if (sel < 4) return {m_data[sel[1:0]], 4'h0};
        return 8'h00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_data[i]  = 4'h0;
            m_valid[i] = 1'b0;
        end
    endtask

    // Apply one cycle of stimulus, advance the model and queue the expected uo_out.
    task automatic drive(input logic [7:0] ui, input logic en);
        logic [3:0] td;
        logic       tv;
        ui_in = ui;
        ena   = en;
        if (en) begin
            if (ui[7]) begin
                model_clear();
            end else if (ui[5:4] == 2'b01 || ui[5:4] == 2'b11) begin
                td = m_data[3];
                tv = m_valid[3];
                for (int i = 3; i > 0; i--) begin
                    m_data[i]  = m_data[i-1];
                    m_valid[i] = m_valid[i-1];
                end
                if (ui[5:4] == 2'b01) begin
                    m_data[0]  = ui[3:0];
                    m_valid[0] = ui[6];
                end else begin
                    m_data[0]  = td;
                    m_valid[0] = tv;
                end
            end
        end
        exp_q.push_back(model_uo());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            ui_in = 8'($urandom);
            @(posedge clk);
            #1;
        end
        model_clear();
        e = 8'h00;
        vectors++;
        if (uo_out !== e) begin
            miscompares++;
            $display("FAIL reset_uo_out got=%h exp=%h", uo_out, e);
        end
        vectors++;
        if (uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_uio_out got=%h exp=00", uio_out);
        end
        vectors++;
        if (uio_oe !== 8'hF0) begin
            miscompares++;
            $display("FAIL reset_uio_oe got=%h exp=f0", uio_oe);
        end
        ui_in = 8'h00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        logic [7:0] e;
        for (int k = 1; k <= 4; k++) begin
            drive(8'h50 | 8'(k), 1'b1);
            e = exp_q.pop_front();
            vectors++;
            if (uo_out !== e) begin
                miscompares++;
                $display("FAIL fill_step%0d got=%h exp=%h", k, uo_out, e);
            end
        end
        vectors++;
        if (uo_out !== 8'h91) begin
            miscompares++;
            $display("FAIL fill_full got=%h exp=91", uo_out);
        end
        uio_in = 8'h00;
        #1;
        vectors++;
        if (uio_out !== 8'h40) begin
            miscompares++;
            $display("FAIL fill_tap0 got=%h exp=40", uio_out);
        end
        uio_in = 8'h03;
        #1;
        vectors++;
        if (uio_out !== 8'h10) begin
            miscompares++;
            $display("FAIL fill_tap3 got=%h exp=10", uio_out);
        end
        drive(8'h55, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (uo_out !== e || uo_out[3:0] !== 4'h2) begin
            miscompares++;
            $display("FAIL fill_fifth got=%h exp=%h", uo_out, e);
        end
    endtask

    task automatic test_bubble();
        logic [7:0] e;
        drive(8'h10, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (uo_out !== e || uo_out !== 8'h63) begin
            miscompares++;
            $display("FAIL bubble got=%h exp=63 model=%h", uo_out, e);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] e;
        drive(8'h80, 1'b1);
        void'(exp_q.pop_front());
        for (int k = 1; k <= 4; k++) begin
            drive(8'h50 | 8'(k), 1'b1);
            void'(exp_q.pop_front());
        end
        for (int r = 1; r <= 4; r++) begin
            drive(8'h3F, 1'b1);
            e = exp_q.pop_front();
            vectors++;
            if (uo_out !== e) begin
                miscompares++;
                $display("FAIL rotate_%0d got=%h exp=%h", r, uo_out, e);
            end
            if (r == 1) begin
                vectors++;
                if (uo_out !== 8'h92) begin
                    miscompares++;
                    $display("FAIL rotate_first_tail got=%h exp=92", uo_out);
                end
            end
        end
        for (int s = 0; s < 4; s++) begin
            uio_in = 8'(s);
            #1;
            vectors++;
            if (uio_out !== {4'(4 - s), 4'h0}) begin
                miscompares++;
                $display("FAIL rotate_tap%0d got=%h exp=%h", s, uio_out, {4'(4 - s), 4'h0});
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] e;
        drive(8'h97, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (uo_out !== e || uo_out !== 8'h91) begin
            miscompares++;
            $display("FAIL prio_hold_over_sclr got=%h exp=91", uo_out);
        end
        drive(8'h6A, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (uo_out !== e || uo_out !== 8'h91) begin
            miscompares++;
            $display("FAIL prio_rsvd_mode got=%h exp=91", uo_out);
        end
        drive(8'hD7, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (uo_out !== e || uo_out !== 8'h00) begin
            miscompares++;
            $display("FAIL prio_sclr_over_shift got=%h exp=00", uo_out);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        for (int k = 6; k <= 9; k++) begin
            drive(8'h50 | 8'(k), 1'b1);
            e = exp_q.pop_front();
            vectors++;
            if (uo_out !== e) begin
                miscompares++;
                $display("FAIL async_fill%0d got=%h exp=%h", k, uo_out, e);
            end
        end
        uio_in = 8'h05;
        #1;
        vectors++;
        if (uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL tap_out_of_range got=%h exp=00", uio_out);
        end
        uio_in = 8'h00;
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        vectors++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset got uo=%h uio=%h exp=00/00", uo_out, uio_out);
        end
        #1;
        rst_n = 1'b1;
        drive(8'h5C, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (uo_out !== e || uo_out !== 8'h20) begin
            miscompares++;
            $display("FAIL after_release got=%h exp=20", uo_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic [3:0] sel;
        for (int n = 0; n < 40; n++) begin
            drive(8'($urandom), ($urandom_range(0, 7) != 0));
            e = exp_q.pop_front();
            vectors++;
            if (uo_out !== e) begin
                miscompares++;
                $display("FAIL random_uo_%0d got=%h exp=%h", n, uo_out, e);
            end
            sel    = 4'($urandom_range(0, 15));
            uio_in = {4'($urandom), sel};
            #1;
            vectors++;
            if (uio_out !== model_tap(sel)) begin
                miscompares++;
                $display("FAIL random_tap_%0d sel=%0d got=%h exp=%h", n, sel, uio_out, model_tap(sel));
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_clear();
        test_reset();
        test_fill();
        test_bubble();
        test_rotate();
        test_priority();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
